// File: rtl/mul8_dot_acc_if.sv
// Bundle of the operand stream, the external multiplier port and the result stream.
// The slave modport is the accumulator's view; the master modport is the environment's view.
interface mul8_dot_acc_if #(
  parameter int unsigned ACC_W = 18
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_o;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  mul_o,
    input  out_ready,
    output in_ready,
    output mul_a,
    output mul_b,
    output out_valid,
    output out_sum,
    output out_sat
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output mul_o,
    output out_ready,
    input  in_ready,
    input  mul_a,
    input  mul_b,
    input  out_valid,
    input  out_sum,
    input  out_sat
  );
endinterface

// File: rtl/mul8_dot_acc.sv
// Dot-product accumulator over LEN 8-bit operand pairs using an external 8x8 multiplier.
// The saturating sum is held until the consumer takes it.
module mul8_dot_acc #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 18
) (
  input logic           clk,
  input logic           rst_n,
  mul8_dot_acc_if.slave bus
);

  localparam int unsigned      CntW   = $clog2(LEN + 1);
  localparam logic [CntW-1:0]  LenCnt = CntW'(LEN);
  localparam logic [CntW-1:0]  OneCnt = CntW'(1);

  localparam logic [0:0] StAcc  = 1'b0;
  localparam logic [0:0] StDone = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             p_valid_q, p_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             last_prod;
  logic             res_hs;
  logic [ACC_W:0]   sum_ext;

  assign out_valid = (state_q == StDone);
  assign in_ready  = (count_q < LenCnt) && !out_valid;
  assign accept    = bus.in_valid && in_ready;
  assign res_hs    = out_valid && bus.out_ready;
  // The pending product is always number count_q, so this flags the final one.
  assign last_prod = p_valid_q && (count_q == LenCnt);
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, bus.mul_o};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    p_valid_d = 1'b0;
    acc_d     = acc_q;
    sat_d     = sat_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;

    if (accept) begin
      mul_a_d   = bus.in_a;
      mul_b_d   = bus.in_b;
      p_valid_d = 1'b1;
      count_d   = count_q + OneCnt;
    end

    if (p_valid_q) begin
      if (sum_ext[ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
      end
    end

    unique case (state_q)
      StAcc: begin
        if (last_prod) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_hs) begin
          state_d = StAcc;
          acc_d   = '0;
          sat_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      count_q   <= '0;
      p_valid_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      p_valid_q <= p_valid_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= LenCnt);

  // No product may be in flight while a result is being presented.
  a_done_no_prod: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDone) |-> !p_valid_q);

  a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !bus.out_ready) |=> (out_valid && $stable(acc_q) && $stable(sat_q)));

endmodule

// File: tb/tb_mul8_dot_acc.sv
// Directed bench for mul8_dot_acc with an exact multiplier stub.
module tb_mul8_dot_acc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul8_dot_acc_if #(.ACC_W(18)) bus ();

  mul8_dot_acc #(
    .LEN   (8),
    .ACC_W (18)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mul_o = {8'd0, bus.mul_a} * {8'd0, bus.mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Eight back-to-back beats, then the edge that accumulates the last product.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input string tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 8; i++) tick();
    bus.in_valid = 1'b0;
    chk({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_pre_ready"}, 32'(bus.in_ready), 32'd0);
    tick();
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_hs_sum"}, 32'(bus.out_sum), 32'd0);
    chk({tag, "_hs_sat"}, 32'(bus.out_sat), 32'd0);
    chk({tag, "_hs_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.out_ready = 1'b0;

    // Reset
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_mul_a", 32'(bus.mul_a), 32'd0);

    // Back-to-back ones
    run_frame(8'd1, 8'd1, "b2b");
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_sum", 32'(bus.out_sum), 32'd8);
    chk("b2b_sat", 32'(bus.out_sat), 32'd0);

    // Backpressure with ignored beats
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd99;
    bus.in_b     = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_sum", 32'(bus.out_sum), 32'd8);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    chk("bp_mul_a", 32'(bus.mul_a), 32'd1);
    bus.in_valid = 1'b0;
    handshake("bp");

    // Saturation then recovery
    run_frame(8'd255, 8'd255, "sat");
    chk("sat_valid", 32'(bus.out_valid), 32'd1);
    chk("sat_sum", 32'(bus.out_sum), 32'd262143);
    chk("sat_flag", 32'(bus.out_sat), 32'd1);
    handshake("sat");
    run_frame(8'd2, 8'd3, "rec");
    chk("rec_sum", 32'(bus.out_sum), 32'd48);
    chk("rec_sat", 32'(bus.out_sat), 32'd0);
    handshake("rec");

    // Bubbles between beats; bubble data is garbage
    for (int k = 1; k <= 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'(k);
      bus.in_b     = 8'd1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_a     = 8'd77;
      bus.in_b     = 8'd77;
      tick();
    end
    chk("bub_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_sum", 32'(bus.out_sum), 32'd36);
    handshake("bub");

    // Mid-frame reset after three beats of 10*10
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd10;
    bus.in_b     = 8'd10;
    for (int i = 0; i < 3; i++) tick();
    bus.in_valid = 1'b0;
    chk("mid_partial", 32'(bus.out_sum), 32'd200);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(bus.out_sum), 32'd0);
    chk("mid_rst_mul_a", 32'(bus.mul_a), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_post_sum", 32'(bus.out_sum), 32'd0);
    run_frame(8'd1, 8'd1, "mid");
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_sum", 32'(bus.out_sum), 32'd8);
    handshake("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
